// File: rtl/waterfall_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : waterfall_sched_pkg
// Purpose : Shared definitions for the waterfall line scheduler: default
//           sample width and line length, stored pixel width, and the
//           write-side FSM state encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package waterfall_sched_pkg;

  localparam int SAMPLE_WIDTH_DEF = 12;
  localparam int LINE_LEN_DEF     = 256;
  localparam int PIX_W            = 8;

  // FILL: collecting samples into the write bank.
  // FULL: write bank holds a complete line waiting for a line_start.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/waterfall_sched_line_ram.sv
`default_nettype none
// ============================================================================
// Module  : line_ram
// Purpose : Simple dual-port RAM holding both ping-pong line banks,
//           2*LINE_LEN words of PIX_W bits, with a registered read port.
//           Address = {bank, offset}.
// Ports   : clk      - clock
//           we_i     - write enable
//           waddr_i  - write address {bank, offset}
//           wdata_i  - write data
//           re_i     - read enable (read register holds when low)
//           raddr_i  - read address {bank, offset}
//           rdata_o  - registered read data
// Revision: 1.0  initial release
// ============================================================================
module line_ram
  import waterfall_sched_pkg::*;
#(
  parameter  int LINE_LEN = LINE_LEN_DEF,
  localparam int AW       = $clog2(2 * LINE_LEN)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [2*LINE_LEN];
  logic [PIX_W-1:0] rdata_q;

  // Storage is deliberately not reset: contents survive a reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/waterfall_sched.sv
`default_nettype none
// ============================================================================
// Module  : waterfall_sched
// Purpose : Ping-pong line scheduler between a decimated ADC sample stream
//           and an LCD pixel fetch interface. One bank fills while the
//           other is displayed; banks swap on line_start once a full line
//           is ready, otherwise the previous line is repeated.
// Ports   : clk        - pixel clock
//           resetn     - asynchronous active-low reset
//           adc_ready  - sample strobe, adc_data valid this cycle
//           adc_data   - ADC sample
//           decim      - keep one sample of every decim+1
//           line_start - start of display line pulse
//           pix_req    - next-pixel request
//           pix_data   - pixel intensity (1 cycle after pix_req)
//           pix_valid  - pix_data valid
//           overrun    - sticky: sample dropped while line was full
//           underrun   - sticky: line repeated because fill incomplete
// Revision: 1.0  initial release
// ============================================================================
module waterfall_sched
  import waterfall_sched_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int LINE_LEN     = LINE_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    adc_ready,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic [3:0]              decim,
  input  logic                    line_start,
  input  logic                    pix_req,
  output logic [PIX_W-1:0]        pix_data,
  output logic                    pix_valid,
  output logic                    overrun,
  output logic                    underrun
);

  localparam int AW = $clog2(LINE_LEN);
  localparam logic [AW-1:0] C_WADDR_ONE = 1;
  localparam logic [AW:0]   C_PTR_ONE   = 1;

  wr_state_e     state_q, state_d;
  logic          wbank_q, wbank_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          pvalid_q, pvalid_d;
  logic          blank_q, blank_d;
  logic          ovr_q, ovr_d;
  logic          unr_q, unr_d;

  logic             w_accept;
  logic             w_swap;
  logic             w_rd_bank;
  logic [AW:0]      w_rd_ptr;
  logic             w_rd_en;
  logic [PIX_W-1:0] w_ram_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_FILL;
      wbank_q  <= 1'b0;
      waddr_q  <= '0;
      dcnt_q   <= '0;
      rptr_q   <= '0;
      pvalid_q <= 1'b0;
      blank_q  <= 1'b0;
      ovr_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wbank_q  <= wbank_d;
      waddr_q  <= waddr_d;
      dcnt_q   <= dcnt_d;
      rptr_q   <= rptr_d;
      pvalid_q <= pvalid_d;
      blank_q  <= blank_d;
      ovr_q    <= ovr_d;
      unr_q    <= unr_d;
    end
  end

  // Write side FSM
  always_comb begin
    state_d  = state_q;
    wbank_d  = wbank_q;
    waddr_d  = waddr_q;
    dcnt_d   = dcnt_q;
    ovr_d    = ovr_q;
    unr_d    = unr_q;
    w_accept = 1'b0;
    w_swap   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (adc_ready) begin
          if (dcnt_q == decim) begin
            w_accept = 1'b1;
            dcnt_d   = '0;
            waddr_d  = waddr_q + C_WADDR_ONE;
            if (&waddr_q) begin
              state_d = ST_FULL;
            end
          end else begin
            dcnt_d = dcnt_q + 4'd1;
          end
        end
        // A line_start that coincides with the completing sample is not a
        // repeat: that line is swapped in at the following line_start.
        if (line_start && !(w_accept && (&waddr_q))) begin
          unr_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (adc_ready) begin
          ovr_d = 1'b1;
        end
        if (line_start) begin
          w_swap  = 1'b1;
          state_d = ST_FILL;
          wbank_d = ~wbank_q;
          waddr_d = '0;
          dcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Read side. On a swap cycle the outgoing write bank is already the read
  // bank, so a coincident pix_req fetches offset 0 of the new line.
  always_comb begin
    w_rd_bank = w_swap ? wbank_q : ~wbank_q;
    w_rd_ptr  = line_start ? '0 : rptr_q;
    w_rd_en   = pix_req && !w_rd_ptr[AW];
    rptr_d    = w_rd_ptr;
    if (w_rd_en) begin
      rptr_d = w_rd_ptr + C_PTR_ONE;
    end
    pvalid_d = pix_req;
    blank_d  = pix_req && w_rd_ptr[AW];
  end

  line_ram #(
    .LINE_LEN (LINE_LEN)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (w_accept),
    .waddr_i ({wbank_q, waddr_q}),
    .wdata_i (adc_data[SAMPLE_WIDTH-1 -: PIX_W]),
    .re_i    (w_rd_en),
    .raddr_i ({w_rd_bank, w_rd_ptr[AW-1:0]}),
    .rdata_o (w_ram_rdata)
  );

  // RAM read register is not reset, so gate it to keep pix_data at 0 out of
  // reset and during the blank tail.
  assign pix_data  = (pvalid_q && !blank_q) ? w_ram_rdata : '0;
  assign pix_valid = pvalid_q;
  assign overrun   = ovr_q;
  assign underrun  = unr_q;

  // Low sample bits are intentionally not stored.
  generate
    if (SAMPLE_WIDTH > PIX_W) begin : g_lsb_sink
      logic unused_adc_lsbs;
      assign unused_adc_lsbs = ^adc_data[SAMPLE_WIDTH-PIX_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_waterfall_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_waterfall_sched
// Purpose : Self-checking bench for waterfall_sched: reset/idle vector
//           table, directed line sequences and randomized traffic against
//           a line-level reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_waterfall_sched;

  localparam int LEN = 256;

  logic        clk;
  logic        resetn;
  logic        adc_ready;
  logic [11:0] adc_data;
  logic [3:0]  decim;
  logic        line_start;
  logic        pix_req;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        overrun;
  logic        underrun;

  waterfall_sched #(
    .SAMPLE_WIDTH (12),
    .LINE_LEN     (LEN)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .adc_ready  (adc_ready),
    .adc_data   (adc_data),
    .decim      (decim),
    .line_start (line_start),
    .pix_req    (pix_req),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .overrun    (overrun),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Line-level reference model: the line being collected, whether it is
  // complete, and the line currently on display.
  logic [7:0] fill_q [$];
  bit         m_full;
  int         shown [LEN];
  bit         shown_known;
  int         m_rptr;
  int         m_dcnt;
  bit         m_ovr;
  bit         m_unr;
  bit         exp_valid;
  bit         exp_known;
  int         exp_data;

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fill_q.delete();
    m_full      = 0;
    shown_known = 0;
    m_rptr      = 0;
    m_dcnt      = 0;
    m_ovr       = 0;
    m_unr       = 0;
    exp_valid   = 0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit ar, input logic [11:0] d, input bit ls, input bit pr);
    int idx;
    bit done;
    adc_ready  = ar;
    adc_data   = d;
    line_start = ls;
    pix_req    = pr;
    @(posedge clk);
    done = 0;
    if (m_full) begin
      if (ar) m_ovr = 1;
      if (ls) begin
        for (int k = 0; k < LEN; k++) shown[k] = int'(fill_q[k]);
        shown_known = 1;
        fill_q.delete();
        m_full = 0;
        m_dcnt = 0;
      end
    end else begin
      if (ar) begin
        if (m_dcnt == int'(decim)) begin
          fill_q.push_back(d[11:4]);
          m_dcnt = 0;
          if (fill_q.size() == LEN) begin
            m_full = 1;
            done   = 1;
          end
        end else begin
          m_dcnt = (m_dcnt + 1) % 16;
        end
      end
      if (ls && !done) m_unr = 1;
    end
    idx       = ls ? 0 : m_rptr;
    exp_valid = pr;
    exp_known = 0;
    exp_data  = 0;
    if (pr) begin
      if (idx < LEN) begin
        exp_data  = shown[idx];
        exp_known = shown_known;
        idx++;
      end else begin
        exp_known = 1;
      end
    end
    m_rptr = idx;
    #1;
    check("model_pix_valid", int'(pix_valid), int'(exp_valid));
    check("model_overrun", int'(overrun), int'(m_ovr));
    check("model_underrun", int'(underrun), int'(m_unr));
    if (exp_valid && exp_known) check("model_pix_data", int'(pix_data), exp_data);
  endtask

  // Assert reset between edges, check outputs drop at once, release on a
  // falling edge.
  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_data", int'(pix_data), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_underrun", int'(underrun), 0);
    model_reset();
    adc_ready  = 1'b0;
    adc_data   = '0;
    line_start = 1'b0;
    pix_req    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [7:0] pat(input int kind, input int i);
    case (kind)
      0:       pat = 8'(i);
      1:       pat = 8'(3 * i + 1);
      2:       pat = 8'(255 - i);
      4:       pat = 8'(i + 7);
      default: pat = 8'(5 * i + 2);
    endcase
  endfunction

  task automatic fill(input int kind, input int start, input int n);
    for (int i = start; i < start + n; i++) step(1'b1, {pat(kind, i), 4'h0}, 1'b0, 1'b0);
  endtask

  task automatic read_check(input string nm, input int kind, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 12'h0, 1'b0, 1'b1);
      check(nm, int'(pix_data), int'(pat(kind, k)));
    end
  endtask

  typedef struct {
    bit          ar;
    logic [11:0] d;
    bit          ls;
    bit          pr;
    bit          ev;
    bit          eo;
    bit          eu;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{ar: 0, d: 12'h000, ls: 0, pr: 0, ev: 0, eo: 0, eu: 0};
    tbl[1] = '{ar: 0, d: 12'h000, ls: 0, pr: 1, ev: 1, eo: 0, eu: 0};
    tbl[2] = '{ar: 0, d: 12'h000, ls: 0, pr: 0, ev: 0, eo: 0, eu: 0};
    tbl[3] = '{ar: 0, d: 12'h000, ls: 1, pr: 0, ev: 0, eo: 0, eu: 1};
    tbl[4] = '{ar: 1, d: 12'hAB0, ls: 0, pr: 0, ev: 0, eo: 0, eu: 1};
    tbl[5] = '{ar: 0, d: 12'h000, ls: 1, pr: 1, ev: 1, eo: 0, eu: 1};
    tbl[6] = '{ar: 0, d: 12'h000, ls: 0, pr: 0, ev: 0, eo: 0, eu: 1};

    resetn     = 1'b1;
    adc_ready  = 1'b0;
    adc_data   = '0;
    decim      = 4'd0;
    line_start = 1'b0;
    pix_req    = 1'b0;
    async_reset();

    // Reset / idle / early line_start vectors
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].ar, tbl[i].d, tbl[i].ls, tbl[i].pr);
      check($sformatf("tbl%0d_valid", i), int'(pix_valid), int'(tbl[i].ev));
      check($sformatf("tbl%0d_ovr", i), int'(overrun), int'(tbl[i].eo));
      check($sformatf("tbl%0d_unr", i), int'(underrun), int'(tbl[i].eu));
    end

    // Full line at decim=0, swap, read back, then blank tail
    async_reset();
    decim = 4'd0;
    fill(0, 0, LEN);
    check("line_ovr_clear", int'(overrun), 0);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    read_check("line_pix", 0, LEN);
    for (int k = 0; k < 44; k++) begin
      step(1'b0, 12'h0, 1'b0, 1'b1);
      check("tail_valid", int'(pix_valid), 1);
      check("tail_data", int'(pix_data), 0);
    end

    // Overrun: 10 extra samples after the line is complete
    fill(1, 0, LEN);
    for (int k = 0; k < 10; k++) step(1'b1, 12'hFFF, 1'b0, 1'b0);
    check("ovr_set", int'(overrun), 1);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    read_check("ovr_first_line", 1, LEN);

    // Underrun after 100 samples, repeat, continue filling at offset 100
    fill(2, 0, 100);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    check("unr_set", int'(underrun), 1);
    read_check("unr_repeat", 1, 3);
    fill(2, 100, LEN - 100);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    read_check("unr_continue", 2, LEN);

    // Final sample coinciding with line_start, then swap with same-cycle read
    async_reset();
    decim = 4'd0;
    fill(5, 0, LEN - 1);
    step(1'b1, {pat(5, LEN - 1), 4'h0}, 1'b1, 1'b0);
    check("coinc_no_unr", int'(underrun), 0);
    step(1'b0, 12'h0, 1'b1, 1'b1);
    check("swap_read_addr0", int'(pix_data), int'(pat(5, 0)));
    for (int k = 1; k < LEN; k++) step(1'b0, 12'h0, 1'b0, 1'b1);
    check("coinc_last_pix", int'(pix_data), int'(pat(5, LEN - 1)));

    // decim=3 ramp: keeps samples 3, 7, 11, ...
    async_reset();
    decim = 4'd3;
    for (int i = 0; i < 4 * LEN; i++) step(1'b1, 12'(i), 1'b0, 1'b0);
    step(1'b1, 12'h0, 1'b0, 1'b0);
    check("decim_full_ovr", int'(overrun), 1);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    check("decim_no_unr", int'(underrun), 0);
    for (int k = 0; k < LEN; k++) begin
      step(1'b0, 12'h0, 1'b0, 1'b1);
      check("decim_pix", int'(pix_data), ((4 * k + 3) >> 4) & 255);
    end

    // Reset mid-fill at offset 50, next line starts at offset 0
    decim = 4'd0;
    fill(4, 0, 50);
    step(1'b0, 12'h0, 1'b0, 1'b1);
    check("pre_rst_valid", int'(pix_valid), 1);
    check("pre_rst_ovr", int'(overrun), 1);
    async_reset();
    fill(4, 0, LEN);
    step(1'b0, 12'h0, 1'b1, 1'b1);
    check("post_rst_addr0", int'(pix_data), int'(pat(4, 0)));

    // Randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      async_reset();
      decim = 4'($urandom_range(0, 2));
      for (int c = 0; c < 6000; c++) begin
        step(1'($urandom_range(0, 1)), 12'($urandom), ($urandom_range(0, 399) == 0),
             1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
